task_unit_arbiter: RTL and testbench
====================================

// Module: task_unit_arbiter
//
// PURPOSE
// - Round-robin arbiter and sequencer for one shared compute unit.
// - The unit is a package task with an output argument: my_pkg::add_one(input [W-1:0] a, output [W-1:0] x), x = a + 1.
// - N requesters each present an argument. The block grants one requester at a time and holds the operand.
// - After LAT cycles it calls the task and returns the result with a valid/ready response handshake.
// - Purpose in the codebase: exercise task output arguments inside clocked logic, together with an FSM and arbitration.
//
// PARAMETERS
// - N    default 4  number of requesters, >= 2
// - W    default 8  operand/result width, >= 1
// - LAT  default 2  cycles from grant to result, >= 1
// - IDW  default $clog2(N)  requester index width; IDW = 1 when N = 2
//
// PORTS
// - clk        in   1      single clock; all state updates on the rising edge
// - rst        in   1      synchronous, active-high reset
// - req        in   N      per-requester request level
// - arg        in   N*W    per-requester operand; requester i uses arg[i*W +: W]
// - gnt        out  N      one-hot grant pulse, one cycle wide
// - busy       out  1      high in every state except IDLE
// - rsp_valid  out  1      result available
// - rsp_ready  in   1      consumer accepts the result
// - rsp_id     out  IDW    index of the requester that owns the result
// - rsp_data   out  W      result value
//
// BEHAVIOUR
// - Reset (rst = 1 at a clock edge):
//   - state = IDLE; gnt = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0.
//   - cnt = 0; last = N-1, so requester 0 has top priority after reset.
// - Reset mid-operation: rst dominates every other input. The in-flight operation is abandoned and no response is issued.
// - IDLE, req != 0:
//   - Winner = first set bit of req, searching from last+1 upward and wrapping modulo N.
//   - On that edge: gnt <= onehot(winner), op <= arg[winner], id <= winner, cnt <= LAT-1, state <= BUSY.
// - IDLE, req == 0: remain in IDLE with gnt = 0.
// - BUSY:
//   - gnt returns to 0 on the first BUSY cycle.
//   - While cnt != 0: cnt <= cnt-1.
//   - When cnt == 0: call my_pkg::add_one(op, res); rsp_data <= res, rsp_id <= id, rsp_valid <= 1, state <= RESP.
// - RESP:
//   - Hold rsp_valid, rsp_id and rsp_data stable until rsp_valid && rsp_ready is seen at a clock edge.
//   - On that edge: rsp_valid <= 0, last <= id, state <= IDLE.
//   - rsp_data keeps its last value after the response is accepted.
// - Latency:
//   - rsp_valid rises exactly LAT cycles after the gnt pulse.
//   - Minimum spacing between two grants is LAT+2 cycles (rsp_ready held high).
// - Handshake rules for requesters:
//   - Hold req and arg stable until the gnt pulse.
//   - req may drop after the grant. Changes to req or arg during BUSY or RESP are ignored; the operand was latched at grant.
// - Arithmetic: result is W bits and wraps, so all-ones + 1 = 0. No carry output.
// - Simultaneous requests: only one winner per grant. Losers keep waiting and are never granted twice in a row while others request, so there is no starvation.
// - rsp_ready while rsp_valid = 0: ignored.
// - The task output variable (res) is an internal temporary. It must never create a latch or an undriven net.
//
// TESTING
// - Reset: assert rst for 2 cycles -> gnt = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, busy = 0.
// - Single request, LAT = 2, rsp_ready = 1: req = 4'b0001, arg0 = 8'h05 at cycle 0
//   -> gnt = 4'b0001 in cycle 1; rsp_valid in cycle 3 with rsp_id = 0, rsp_data = 8'h06.
// - Fairness: req = 4'b1111 held, args 8'h10/8'h20/8'h30/8'h40, rsp_ready = 1
//   -> grants in order 0,1,2,3,0; data 8'h11/8'h21/8'h31/8'h41; grants exactly LAT+2 = 4 cycles apart.
// - Wrap-around: arg2 = 8'hFF, req = 4'b0100 -> rsp_id = 2, rsp_data = 8'h00.
// - Backpressure: hold rsp_ready = 0 for 5 cycles with req = 4'b0011 pending
//   -> rsp_valid and rsp_data stay stable; no new gnt; next grant goes to requester 1.
// - Reset mid-operation: pulse rst on the second BUSY cycle -> no rsp_valid; next grant goes to requester 0.

Source files
------------

// File: rtl/task_unit_arbiter.sv
// Round-robin arbiter that sequences N requesters onto one shared add-one unit
// (a package task with an output argument) and returns results over valid/ready.

package my_pkg;
    // Widest operand the shared unit supports; callers zero-extend and truncate.
    localparam int MAX_W = 64;

    task automatic add_one(input logic [MAX_W-1:0] a, output logic [MAX_W-1:0] x);
        x = a + 1'b1;
    endtask
endpackage

module task_unit_arbiter #(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int LAT = 2,
    parameter int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] arg,
    output logic [N-1:0]   gnt,
    output logic           busy,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [IDW-1:0] rsp_id,
    output logic [W-1:0]   rsp_data
);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int XW = my_pkg::MAX_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]     state;
    logic [IDW-1:0] last;
    logic [IDW-1:0] id;
    logic [W-1:0]   op;
    logic [CW-1:0]  cnt;

    logic [IDW-1:0] win_idx;
    logic           win_found;
    logic [W-1:0]   arg_arr [N];
    logic [XW-1:0]  res_wide;

    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int k);
        return IDW'((int'(base) + k) % N);
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) begin
            arg_arr[i] = arg[i*W +: W];
        end
    end

    // Search begins one past the last served requester, so a requester that was
    // just served has the lowest priority on the next grant.
    always_comb begin
        // NOTE: outputs of a combinational block get a default first, so no path can infer a latch.
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            if (!win_found && req[rr_index(last, k)]) begin
                win_found = 1'b1;
                win_idx   = rr_index(last, k);
            end
        end
    end

    always_comb begin
        res_wide = '0;
        my_pkg::add_one(XW'(op), res_wide);
    end

    // Bits above W are carries out of the wrapped result and are dropped.
    if (W < XW) begin : g_res_hi
        logic unused_res_hi;
        assign unused_res_hi = ^res_wide[XW-1:W];
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every branch sees pre-edge values.
        if (rst) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            cnt       <= '0;
            last      <= IDW'(N - 1);
            id        <= '0;
            op        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    gnt <= '0;
                    if (win_found) begin
                        gnt   <= N'(1) << win_idx;
                        op    <= arg_arr[win_idx];
                        id    <= win_idx;
                        cnt   <= CW'(LAT - 1);
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    gnt <= '0;
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        rsp_data  <= res_wide[W-1:0];
                        rsp_id    <= id;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    gnt <= '0;
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        last      <= id;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    gnt       <= '0;
                    rsp_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_task_unit_arbiter.sv
// Bench for task_unit_arbiter: directed scenarios plus randomized traffic, all
// outputs compared every cycle against a transaction-level reference model.

module tb_task_unit_arbiter;
    localparam int N   = 4;
    localparam int W   = 8;
    localparam int LAT = 2;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] arg = '0;
    logic           rsp_ready = 1'b0;
    logic [N-1:0]   gnt;
    logic           busy;
    logic           rsp_valid;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_data;

    task_unit_arbiter #(.N(N), .W(W), .LAT(LAT), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .arg       (arg),
        .gnt       (gnt),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: one operation in flight, result due LAT edges after its grant.
    bit           m_idle   = 1'b1;
    bit           m_valid  = 1'b0;
    int           m_last   = N - 1;
    int           m_owner  = 0;
    int           m_rsp_at = 0;
    int           m_id     = 0;
    logic [W-1:0] m_res    = '0;
    logic [W-1:0] m_data   = '0;
    logic [N-1:0] exp_gnt  = '0;

    int           gnt_q[$];
    int           gnt_cyc_q[$];
    int           rsp_id_q[$];
    int           rsp_cyc_q[$];
    logic [W-1:0] rsp_data_q[$];
    logic         prev_valid = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [N*W-1:0] pack(input logic [W-1:0] a0, input logic [W-1:0] a1,
                                            input logic [W-1:0] a2, input logic [W-1:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic model_edge(input logic [N-1:0] r, input logic [N*W-1:0] a,
                              input logic rdy, input logic rs);
        int           w;
        logic [W-1:0] opnd;
        exp_gnt = '0;
        if (rs) begin
            m_idle  = 1'b1;
            m_valid = 1'b0;
            m_last  = N - 1;
            m_id    = 0;
            m_data  = '0;
        end else if (m_idle) begin
            w = -1;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (w < 0 && r[c]) w = c;
            end
            if (w >= 0) begin
                opnd = '0;
                for (int i = 0; i < N; i++) begin
                    if (i == w) opnd = a[i*W +: W];
                end
                exp_gnt[w] = 1'b1;
                m_owner    = w;
                m_res      = opnd + 1'b1;
                m_rsp_at   = cyc + LAT;
                m_idle     = 1'b0;
            end
        end else if (m_valid) begin
            if (rdy) begin
                m_valid = 1'b0;
                m_last  = m_owner;
                m_idle  = 1'b1;
            end
        end else if (cyc == m_rsp_at) begin
            m_valid = 1'b1;
            m_id    = m_owner;
            m_data  = m_res;
        end
    endtask

    task automatic step(input logic [N-1:0] r, input logic [N*W-1:0] a,
                        input logic rdy, input logic rs);
        @(negedge clk);
        req       = r;
        arg       = a;
        rsp_ready = rdy;
        rst       = rs;
        model_edge(r, a, rdy, rs);
        @(posedge clk);
        #1;
        check("gnt", gnt, exp_gnt);
        check("rsp_valid", rsp_valid, m_valid);
        check("busy", busy, !m_idle);
        check("rsp_id", rsp_id, m_id);
        check("rsp_data", rsp_data, m_data);
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                gnt_q.push_back(i);
                gnt_cyc_q.push_back(cyc);
            end
        end
        if (rsp_valid && !prev_valid) begin
            rsp_id_q.push_back(int'(rsp_id));
            rsp_data_q.push_back(rsp_data);
            rsp_cyc_q.push_back(cyc);
        end
        prev_valid = rsp_valid;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step('0, '0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        step('0, '0, 1'b1, 1'b1);
        step('0, '0, 1'b1, 1'b1);
    endtask

    task automatic clear_logs();
        gnt_q.delete();
        gnt_cyc_q.delete();
        rsp_id_q.delete();
        rsp_data_q.delete();
        rsp_cyc_q.delete();
    endtask

    initial begin
        logic [N*W-1:0] a;
        logic [N-1:0]   r;
        int             t0;

        do_reset();
        check("reset_gnt", gnt, 0);
        check("reset_valid", rsp_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_id", rsp_id, 0);
        check("reset_data", rsp_data, 0);

        // Single request from requester 0.
        clear_logs();
        t0 = cyc;
        step(4'b0001, pack(8'h05, 8'h00, 8'h00, 8'h00), 1'b1, 1'b0);
        idle(5);
        check("single_ngnt", gnt_q.size(), 1);
        check("single_nrsp", rsp_id_q.size(), 1);
        if (gnt_q.size() == 1 && rsp_id_q.size() == 1) begin
            check("single_gnt_idx", gnt_q[0], 0);
            check("single_gnt_cyc", gnt_cyc_q[0], t0);
            check("single_rsp_id", rsp_id_q[0], 0);
            check("single_rsp_data", rsp_data_q[0], 8'h06);
            check("single_latency", rsp_cyc_q[0] - gnt_cyc_q[0], LAT);
        end

        // Fairness with all four requesting.
        do_reset();
        clear_logs();
        a = pack(8'h10, 8'h20, 8'h30, 8'h40);
        repeat (5 * (LAT + 2)) step(4'b1111, a, 1'b1, 1'b0);
        idle(8);
        check("fair_ngnt", gnt_q.size(), 5);
        check("fair_nrsp", rsp_id_q.size(), 5);
        if (gnt_q.size() == 5 && rsp_id_q.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                check("fair_order", gnt_q[i], i % N);
                check("fair_data", rsp_data_q[i], 8'h11 + 8'(16 * (i % N)));
                if (i > 0) check("fair_spacing", gnt_cyc_q[i] - gnt_cyc_q[i-1], LAT + 2);
            end
        end

        // Wrap-around of the all-ones operand.
        do_reset();
        clear_logs();
        step(4'b0100, pack(8'h00, 8'h00, 8'hFF, 8'h00), 1'b1, 1'b0);
        idle(5);
        check("wrap_nrsp", rsp_id_q.size(), 1);
        if (rsp_id_q.size() == 1) begin
            check("wrap_id", rsp_id_q[0], 2);
            check("wrap_data", rsp_data_q[0], 8'h00);
        end

        // Backpressure with two requesters pending.
        clear_logs();
        a = pack(8'h33, 8'h44, 8'h00, 8'h00);
        repeat (LAT + 1) step(4'b0011, a, 1'b0, 1'b0);
        check("bp_valid", rsp_valid, 1);
        check("bp_data", rsp_data, 8'h34);
        repeat (5) begin
            step(4'b0011, a, 1'b0, 1'b0);
            check("bp_hold_valid", rsp_valid, 1);
            check("bp_hold_data", rsp_data, 8'h34);
            check("bp_hold_id", rsp_id, 0);
            check("bp_no_gnt", gnt, 0);
        end
        repeat (4) step(4'b0011, a, 1'b1, 1'b0);
        idle(6);
        check("bp_ngnt", gnt_q.size(), 2);
        if (gnt_q.size() == 2) begin
            check("bp_first_gnt", gnt_q[0], 0);
            check("bp_next_gnt", gnt_q[1], 1);
        end

        // Serve requester 0 so a reset that failed to restore priority would be visible.
        step(4'b0001, pack(8'h01, 8'h00, 8'h00, 8'h00), 1'b1, 1'b0);
        idle(5);

        // Reset on the second BUSY cycle abandons the operation.
        clear_logs();
        step(4'b0100, pack(8'h00, 8'h00, 8'h77, 8'h00), 1'b1, 1'b0);
        step('0, '0, 1'b1, 1'b0);
        step('0, '0, 1'b1, 1'b1);
        idle(4);
        check("mr_no_rsp", rsp_id_q.size(), 0);
        step(4'b0011, pack(8'h0A, 8'h0B, 8'h00, 8'h00), 1'b1, 1'b0);
        idle(5);
        check("mr_ngnt", gnt_q.size(), 2);
        if (gnt_q.size() == 2) check("mr_next_gnt", gnt_q[1], 0);
        check("mr_nrsp", rsp_id_q.size(), 1);

        // Randomized traffic with backpressure and occasional reset.
        repeat (800) begin
            r = N'($urandom_range(0, (1 << N) - 1));
            if ($urandom_range(0, 3) == 0) r = '0;
            for (int i = 0; i < N; i++) a[i*W +: W] = W'($urandom);
            step(r, a, $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
        end
        idle(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
